// File: rtl/square_decoder.sv
// Square-wave receiver: recovers the per-level hold length and tone lock.
// Optional spike filter on the sliced level: SQUARE_DECODER_GLITCH_EN.
module square_decoder #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] THRESHOLD = WIDTH'(128),
  parameter logic [WIDTH-1:0] TOL       = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] square_in,
  output logic [WIDTH-1:0] freq_out,
  output logic             freq_valid,
  output logic             locked
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_IDLE,
    S_MEAS
  } state_e;

  state_e           state_q;
  logic             lvl;
  logic             lvl_q;
  logic             edge_w;
  logic             sat;
  logic             first_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] diff;

  assign lvl = (square_in >= THRESHOLD);
  assign sat = (count_q == CNT_MAX);

`ifdef SQUARE_DECODER_GLITCH_EN
  logic raw_q;

  // a level must be seen twice in a row before it is accepted
  assign edge_w = (lvl == raw_q) && (lvl != lvl_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      raw_q <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      raw_q <= lvl;
      if (edge_w)
        lvl_q <= lvl;
    end
  end
`else
  assign edge_w = (lvl != lvl_q);

  always_ff @(posedge clk) begin
    if (!reset_n)
      lvl_q <= 1'b0;
    else
      lvl_q <= lvl;
  end
`endif

  assign diff = (count_q >= prev_q) ? (count_q - prev_q)
                                    : (prev_q - count_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      prev_q     <= '0;
      first_q    <= 1'b0;
      freq_out   <= '0;
      freq_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      freq_valid <= 1'b0;

      if (edge_w)
        count_q <= WIDTH'(1);
      else if (!sat)
        count_q <= count_q + WIDTH'(1);

      unique case (state_q)
        S_IDLE: begin
          locked <= 1'b0;
          if (edge_w) begin
            state_q <= S_MEAS;
            first_q <= 1'b1;
          end
        end
        S_MEAS: begin
          // an edge wins over a simultaneous timeout
          if (edge_w) begin
            freq_out   <= count_q;
            freq_valid <= 1'b1;
            prev_q     <= count_q;
            first_q    <= 1'b0;
            locked     <= first_q ? 1'b0 : (diff <= TOL);
          end else if (sat) begin
            state_q <= S_IDLE;
            locked  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
